cap_charge_ctrl: RTL and testbench

//   Sequencer that commands charge/discharge of resonant capacitors CAP1/CAP2 and consumes the

---
 rtl/cap_ctrl_pkg.sv | 41 ++++
 rtl/cap_chan_fsm.sv | 204 ++++++++++++++++++++
 rtl/cap_charge_ctrl.sv | 102 ++++++++++
 tb/tb_cap_charge_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cap_ctrl_pkg.sv
// Shared definitions for the capacitor charge sequencer: state encoding, fault codes and
// default timing constants.
package cap_ctrl_pkg;

    // Per-channel state encoding
    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_CHARGE_BLNK = 3'd1;
    localparam logic [2:0] ST_CHARGING    = 3'd2;
    localparam logic [2:0] ST_READY       = 3'd3;
    localparam logic [2:0] ST_DISCH_BLNK  = 3'd4;
    localparam logic [2:0] ST_DISCHARGING = 3'd5;
    localparam logic [2:0] ST_FAULT       = 3'd6;

    typedef enum logic [2:0] {
        StIdle        = ST_IDLE,
        StChargeBlank = ST_CHARGE_BLNK,
        StCharging    = ST_CHARGING,
        StReady       = ST_READY,
        StDischBlank  = ST_DISCH_BLNK,
        StDischarging = ST_DISCHARGING,
        StFault       = ST_FAULT
    } cap_state_e;

    localparam logic [1:0] FAULT_NONE   = 2'd0;
    localparam logic [1:0] FAULT_CHG_TO = 2'd1;
    localparam logic [1:0] FAULT_DIS_TO = 2'd2;
    localparam logic [1:0] FAULT_ABORT  = 2'd3;

    localparam int unsigned DEF_BLANK_CYC   = 16;
    localparam int unsigned DEF_TIMEOUT_CYC = 250_000_000;
    localparam int unsigned DEF_TOPUP_CYC   = 64;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned TMO_CNT_W       = 28;

    // States in which the capacitor is actively being driven (abort here is a fault)
    function automatic logic is_in_flight(input cap_state_e st);
        return (st == StChargeBlank) || (st == StCharging) ||
               (st == StDischBlank)  || (st == StDischarging);
    endfunction

endpackage

// File: rtl/cap_chan_fsm.sv
// One capacitor channel: sequencing FSM, blank/timeout/top-up counters and setpoint latch.
// Optional READY top-up recharge is enabled by defining CAP_TOPUP_EN.
module cap_chan_fsm
    import cap_ctrl_pkg::*;
#(
    parameter int unsigned BLANK_CYC   = DEF_BLANK_CYC,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int unsigned TOPUP_CYC   = DEF_TOPUP_CYC
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start_charge_i,
    input  logic       start_discharge_i,
    input  logic       fire_done_i,
    input  logic       abort_i,
    input  logic       fault_clr_i,
    input  logic       rdy_i,
    input  logic [7:0] set_in_i,
    output logic [7:0] cap_set_o,
    output logic       charge_flag_o,
    output logic       discharge_flag_o,
    output logic       charger_en_o,
    output logic       dump_en_o,
    output logic       cap_ready_o,
    output logic       cap_fault_o,
    output logic [1:0] fault_code_o
);

    localparam int unsigned BlankW = $clog2(BLANK_CYC + 1);
    localparam int unsigned TopupW = $clog2(TOPUP_CYC + 1);
    localparam logic [BlankW-1:0]    BlankLast = BlankW'(BLANK_CYC - 1);
    localparam logic [TopupW-1:0]    TopupLast = TopupW'(TOPUP_CYC - 1);
    localparam logic [TMO_CNT_W-1:0] TmoLast   = TMO_CNT_W'(TIMEOUT_CYC - 1);
`ifdef CAP_TOPUP_EN
    localparam logic TopupEn = 1'b1;
`else
    localparam logic TopupEn = 1'b0;
`endif

    cap_state_e           state_q, state_d;
    logic [7:0]           set_q, set_d;
    logic [1:0]           code_q, code_d;
    logic [BlankW-1:0]    blank_cnt_q, blank_cnt_d;
    logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [TopupW-1:0]    topup_cnt_q, topup_cnt_d;

    logic charge_flag_q, charge_flag_d;
    logic discharge_flag_q, discharge_flag_d;
    logic charger_en_q, charger_en_d;
    logic dump_en_q, dump_en_d;
    logic ready_q, ready_d;
    logic fault_q, fault_d;

    logic charge_ok, blank_done, tmo_hit, topup_hit, entering, handoff;

    always_comb begin
        state_d    = state_q;
        set_d      = set_q;
        code_d     = code_q;
        charge_ok  = start_charge_i && (set_in_i != 8'd0);
        blank_done = (blank_cnt_q == BlankLast);
        tmo_hit    = (tmo_cnt_q >= TmoLast);
        topup_hit  = TopupEn && !rdy_i && (topup_cnt_q == TopupLast);

        unique case (state_q)
            StIdle: begin
                if (start_discharge_i) begin
                    state_d = StDischBlank;
                end else if (charge_ok) begin
                    set_d   = set_in_i;
                    state_d = StChargeBlank;
                end
            end
            StChargeBlank: if (blank_done) state_d = StCharging;
            StCharging: begin
                if (rdy_i) begin
                    state_d = StReady;
                end else if (tmo_hit) begin
                    state_d = StFault;
                    code_d  = FAULT_CHG_TO;
                end
            end
            StReady: begin
                if (fire_done_i) begin
                    state_d = StIdle;
                end else if (start_discharge_i) begin
                    state_d = StDischBlank;
                end else if (charge_ok) begin
                    set_d   = set_in_i;
                    state_d = StChargeBlank;
                end else if (topup_hit) begin
                    state_d = StChargeBlank;
                end
            end
            StDischBlank: if (blank_done) state_d = StDischarging;
            StDischarging: begin
                if (rdy_i) begin
                    state_d = StIdle;
                end else if (tmo_hit) begin
                    state_d = StFault;
                    code_d  = FAULT_DIS_TO;
                end
            end
            StFault: begin
                if (fault_clr_i && !abort_i) begin
                    state_d = StIdle;
                    code_d  = FAULT_NONE;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort overrides everything except an existing fault; no setpoint relatch.
        if (abort_i && (state_q != StFault)) begin
            set_d = set_q;
            if (is_in_flight(state_q)) begin
                state_d = StFault;
                code_d  = FAULT_ABORT;
            end else begin
                state_d = StIdle;
                code_d  = FAULT_NONE;
            end
        end
    end

    // The timeout spans blank plus the active phase, so it is not cleared at that handoff.
    always_comb begin
        entering = (state_d != state_q);
        handoff  = ((state_q == StChargeBlank) && (state_d == StCharging)) ||
                   ((state_q == StDischBlank) && (state_d == StDischarging));

        blank_cnt_d = blank_cnt_q;
        if (entering) begin
            blank_cnt_d = '0;
        end else if (blank_cnt_q != BlankLast) begin
            blank_cnt_d = blank_cnt_q + BlankW'(1);
        end

        tmo_cnt_d = tmo_cnt_q;
        if (entering && !handoff) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != '1) begin
            tmo_cnt_d = tmo_cnt_q + TMO_CNT_W'(1);
        end

        topup_cnt_d = topup_cnt_q;
        if (entering || rdy_i) begin
            topup_cnt_d = '0;
        end else if (topup_cnt_q != TopupLast) begin
            topup_cnt_d = topup_cnt_q + TopupW'(1);
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        charge_flag_d    = (state_d == StChargeBlank) || (state_d == StCharging) ||
                           (state_d == StReady);
        charger_en_d     = (state_d == StChargeBlank) || (state_d == StCharging);
        discharge_flag_d = (state_d == StDischBlank) || (state_d == StDischarging);
        dump_en_d        = discharge_flag_d;
        ready_d          = (state_d == StReady);
        fault_d          = (state_d == StFault);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q          <= StIdle;
            set_q            <= 8'd0;
            code_q           <= FAULT_NONE;
            blank_cnt_q      <= '0;
            tmo_cnt_q        <= '0;
            topup_cnt_q      <= '0;
            charge_flag_q    <= 1'b0;
            discharge_flag_q <= 1'b0;
            charger_en_q     <= 1'b0;
            dump_en_q        <= 1'b0;
            ready_q          <= 1'b0;
            fault_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            set_q            <= set_d;
            code_q           <= code_d;
            blank_cnt_q      <= blank_cnt_d;
            tmo_cnt_q        <= tmo_cnt_d;
            topup_cnt_q      <= topup_cnt_d;
            charge_flag_q    <= charge_flag_d;
            discharge_flag_q <= discharge_flag_d;
            charger_en_q     <= charger_en_d;
            dump_en_q        <= dump_en_d;
            ready_q          <= ready_d;
            fault_q          <= fault_d;
        end
    end

    assign cap_set_o        = set_q;
    assign charge_flag_o    = charge_flag_q;
    assign discharge_flag_o = discharge_flag_q;
    assign charger_en_o     = charger_en_q;
    assign dump_en_o        = dump_en_q;
    assign cap_ready_o      = ready_q;
    assign cap_fault_o      = fault_q;
    assign fault_code_o     = code_q;

endmodule

// File: rtl/cap_charge_ctrl.sv
// Two-channel capacitor charge/discharge sequencer: reached-flag synchronizer, abort fan-out
// and two channel FSMs. Define CAP_TOPUP_EN to enable automatic recharge from READY.
module cap_charge_ctrl
    import cap_ctrl_pkg::*;
#(
    parameter int unsigned BLANK_CYC   = DEF_BLANK_CYC,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int unsigned TOPUP_CYC   = DEF_TOPUP_CYC,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [1:0] start_charge,
    input  logic [1:0] start_discharge,
    input  logic [1:0] fire_done,
    input  logic       abort,
    input  logic [1:0] fault_clr,
    input  logic [7:0] set_in_1,
    input  logic [7:0] set_in_2,
    input  logic [1:0] voltage_reached,
    output logic [7:0] cap_set_1,
    output logic [7:0] cap_set_2,
    output logic [1:0] CAP_charge_flag,
    output logic [1:0] CAP_discharge_flag,
    output logic [1:0] charger_en,
    output logic [1:0] dump_en,
    output logic [1:0] cap_ready,
    output logic [1:0] cap_fault,
    output logic [3:0] fault_code
);

    // voltage_reached comes from the adc_clk domain
    logic [SYNC_STAGES-1:0][1:0] sync_q, sync_d;
    logic [1:0]                  rdy;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = voltage_reached;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rdy = sync_q[SYNC_STAGES-1];

    cap_chan_fsm #(
        .BLANK_CYC   (BLANK_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TOPUP_CYC   (TOPUP_CYC)
    ) u_chan1 (
        .sys_clk           (sys_clk),
        .sys_rst_n         (sys_rst_n),
        .start_charge_i    (start_charge[0]),
        .start_discharge_i (start_discharge[0]),
        .fire_done_i       (fire_done[0]),
        .abort_i           (abort),
        .fault_clr_i       (fault_clr[0]),
        .rdy_i             (rdy[0]),
        .set_in_i          (set_in_1),
        .cap_set_o         (cap_set_1),
        .charge_flag_o     (CAP_charge_flag[0]),
        .discharge_flag_o  (CAP_discharge_flag[0]),
        .charger_en_o      (charger_en[0]),
        .dump_en_o         (dump_en[0]),
        .cap_ready_o       (cap_ready[0]),
        .cap_fault_o       (cap_fault[0]),
        .fault_code_o      (fault_code[1:0])
    );

    cap_chan_fsm #(
        .BLANK_CYC   (BLANK_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TOPUP_CYC   (TOPUP_CYC)
    ) u_chan2 (
        .sys_clk           (sys_clk),
        .sys_rst_n         (sys_rst_n),
        .start_charge_i    (start_charge[1]),
        .start_discharge_i (start_discharge[1]),
        .fire_done_i       (fire_done[1]),
        .abort_i           (abort),
        .fault_clr_i       (fault_clr[1]),
        .rdy_i             (rdy[1]),
        .set_in_i          (set_in_2),
        .cap_set_o         (cap_set_2),
        .charge_flag_o     (CAP_charge_flag[1]),
        .discharge_flag_o  (CAP_discharge_flag[1]),
        .charger_en_o      (charger_en[1]),
        .dump_en_o         (dump_en[1]),
        .cap_ready_o       (cap_ready[1]),
        .cap_fault_o       (cap_fault[1]),
        .fault_code_o      (fault_code[3:2])
    );

endmodule

// File: tb/tb_cap_charge_ctrl.sv
// Directed bench for cap_charge_ctrl with short timing (blank 4, timeout 100, top-up 8).
module tb_cap_charge_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic [1:0] start_charge, start_discharge, fire_done, fault_clr, voltage_reached;
    logic       abort;
    logic [7:0] set_in_1, set_in_2;
    logic [7:0] cap_set_1, cap_set_2;
    logic [1:0] CAP_charge_flag, CAP_discharge_flag, charger_en, dump_en, cap_ready, cap_fault;
    logic [3:0] fault_code;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic [1:0] prev_chg = 2'b00;

    always #5 sys_clk = ~sys_clk;

    cap_charge_ctrl #(
        .BLANK_CYC   (4),
        .TIMEOUT_CYC (100),
        .TOPUP_CYC   (8),
        .SYNC_STAGES (2)
    ) dut (
        .sys_clk            (sys_clk),
        .sys_rst_n          (sys_rst_n),
        .start_charge       (start_charge),
        .start_discharge    (start_discharge),
        .fire_done          (fire_done),
        .abort              (abort),
        .fault_clr          (fault_clr),
        .set_in_1           (set_in_1),
        .set_in_2           (set_in_2),
        .voltage_reached    (voltage_reached),
        .cap_set_1          (cap_set_1),
        .cap_set_2          (cap_set_2),
        .CAP_charge_flag    (CAP_charge_flag),
        .CAP_discharge_flag (CAP_discharge_flag),
        .charger_en         (charger_en),
        .dump_en            (dump_en),
        .cap_ready          (cap_ready),
        .cap_fault          (cap_fault),
        .fault_code         (fault_code)
    );

    // Per-cycle safety invariants on both channels
    always @(negedge sys_clk) begin
        if (sys_rst_n === 1'b1) begin
            n_checks++;
            if (((CAP_charge_flag & CAP_discharge_flag) | (charger_en & dump_en) |
                 (prev_chg & dump_en)) !== 2'b00) begin
                n_fail++;
                $display("FAIL invariant: chg_flag=%b dis_flag=%b chg_en=%b dump_en=%b prev_chg=%b required no overlap",
                         CAP_charge_flag, CAP_discharge_flag, charger_en, dump_en, prev_chg);
            end
        end
        prev_chg <= charger_en;
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic to_cycle(input int n);
        while (cyc < n) tick();
    endtask

    task automatic settle();
        repeat (4) tick();
        cyc = 0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        start_charge = '0; start_discharge = '0; fire_done = '0; fault_clr = '0;
        abort = 1'b0; set_in_1 = '0; set_in_2 = '0; voltage_reached = '0;
        #2;
        n_checks++;
        if ({CAP_charge_flag, CAP_discharge_flag, charger_en, dump_en, cap_ready, cap_fault,
             fault_code, cap_set_1, cap_set_2} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got chg=%b dis=%b cen=%b den=%b rdy=%b flt=%b code=%h set=%0d/%0d required all 0",
                     CAP_charge_flag, CAP_discharge_flag, charger_en, dump_en, cap_ready,
                     cap_fault, fault_code, cap_set_1, cap_set_2);
        end
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        settle();
        n_checks++;
        if ({CAP_charge_flag, charger_en, dump_en, cap_fault} !== 8'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got chg=%b cen=%b den=%b flt=%b required 0",
                     CAP_charge_flag, charger_en, dump_en, cap_fault);
        end
    endtask

    task automatic test_charge();
        start_charge = 2'b01; set_in_1 = 8'd50;
        tick();
        start_charge = 2'b00; set_in_1 = 8'd99;
        n_checks++;
        if ({CAP_charge_flag[0], charger_en[0], cap_ready[0], cap_set_1} !== {3'b110, 8'd50}) begin
            n_fail++;
            $display("FAIL chg_start: got flag=%b en=%b rdy=%b set=%0d required 1 1 0 50",
                     CAP_charge_flag[0], charger_en[0], cap_ready[0], cap_set_1);
        end
        to_cycle(20);
        voltage_reached[0] = 1'b1;
        to_cycle(22);
        n_checks++;
        if ({cap_ready[0], charger_en[0]} !== 2'b01) begin
            n_fail++;
            $display("FAIL chg_sync_lat: cycle 22 got rdy=%b en=%b required 0 1", cap_ready[0], charger_en[0]);
        end
        to_cycle(23);
        n_checks++;
        if ({cap_ready[0], charger_en[0], CAP_charge_flag[0]} !== 3'b101) begin
            n_fail++;
            $display("FAIL chg_ready: cycle 23 got rdy=%b en=%b flag=%b required 1 0 1",
                     cap_ready[0], charger_en[0], CAP_charge_flag[0]);
        end
        cyc = 0;
    endtask

    task automatic test_timeout();
        start_charge = 2'b10; set_in_2 = 8'd80;
        tick();
        start_charge = 2'b00;
        to_cycle(100);
        n_checks++;
        if ({cap_fault[1], charger_en[1]} !== 2'b01) begin
            n_fail++;
            $display("FAIL tmo_early: cycle 100 got flt=%b en=%b required 0 1", cap_fault[1], charger_en[1]);
        end
        to_cycle(101);
        n_checks++;
        if ({cap_fault[1], fault_code[3:2], charger_en[1], CAP_charge_flag[1], cap_set_2} !==
            {1'b1, 2'd1, 2'b00, 8'd80}) begin
            n_fail++;
            $display("FAIL tmo_fault: got flt=%b code=%0d en=%b flag=%b set=%0d required 1 1 0 0 80",
                     cap_fault[1], fault_code[3:2], charger_en[1], CAP_charge_flag[1], cap_set_2);
        end
        fault_clr = 2'b10;
        tick();
        fault_clr = 2'b00;
        n_checks++;
        if ({cap_fault[1], fault_code[3:2], cap_ready[1]} !== 4'b0000) begin
            n_fail++;
            $display("FAIL tmo_clear: got flt=%b code=%0d rdy=%b required 0 0 0",
                     cap_fault[1], fault_code[3:2], cap_ready[1]);
        end
        cyc = 0;
    endtask

    task automatic test_discharge();
        start_discharge = 2'b01; voltage_reached[0] = 1'b0;
        tick();
        start_discharge = 2'b00;
        n_checks++;
        if ({dump_en[0], CAP_discharge_flag[0], CAP_charge_flag[0], charger_en[0], cap_ready[0]} !==
            5'b11000) begin
            n_fail++;
            $display("FAIL dis_start: got den=%b dflag=%b cflag=%b cen=%b rdy=%b required 1 1 0 0 0",
                     dump_en[0], CAP_discharge_flag[0], CAP_charge_flag[0], charger_en[0], cap_ready[0]);
        end
        to_cycle(2);
        voltage_reached[0] = 1'b1;
        tick();
        voltage_reached[0] = 1'b0;
        to_cycle(6);
        n_checks++;
        if (dump_en[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL dis_blank_ignore: cycle 6 got den=%b required 1", dump_en[0]);
        end
        to_cycle(30);
        voltage_reached[0] = 1'b1;
        to_cycle(32);
        n_checks++;
        if (dump_en[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL dis_sync_lat: cycle 32 got den=%b required 1", dump_en[0]);
        end
        to_cycle(33);
        n_checks++;
        if ({dump_en[0], CAP_discharge_flag[0], cap_set_1} !== {2'b00, 8'd50}) begin
            n_fail++;
            $display("FAIL dis_idle: cycle 33 got den=%b dflag=%b set=%0d required 0 0 50",
                     dump_en[0], CAP_discharge_flag[0], cap_set_1);
        end
        voltage_reached[0] = 1'b0;
        settle();
    endtask

    task automatic test_simultaneous();
        start_charge = 2'b01; start_discharge = 2'b01; set_in_1 = 8'd70;
        tick();
        start_charge = 2'b00; start_discharge = 2'b00;
        n_checks++;
        if ({CAP_discharge_flag[0], CAP_charge_flag[0], cap_set_1} !== {2'b10, 8'd50}) begin
            n_fail++;
            $display("FAIL simul_dis_wins: got dflag=%b cflag=%b set=%0d required 1 0 50",
                     CAP_discharge_flag[0], CAP_charge_flag[0], cap_set_1);
        end
        to_cycle(6);
        voltage_reached[0] = 1'b1;
        to_cycle(9);
        n_checks++;
        if ({dump_en[0], CAP_charge_flag[0]} !== 2'b00) begin
            n_fail++;
            $display("FAIL simul_idle: got den=%b cflag=%b required 0 0", dump_en[0], CAP_charge_flag[0]);
        end
        voltage_reached[0] = 1'b0;
        settle();
    endtask

    task automatic test_zero_setpoint();
        start_charge = 2'b10; set_in_2 = 8'd0;
        tick();
        start_charge = 2'b00;
        n_checks++;
        if ({CAP_charge_flag[1], charger_en[1], cap_set_2} !== {2'b00, 8'd80}) begin
            n_fail++;
            $display("FAIL zero_set_ignored: got flag=%b en=%b set=%0d required 0 0 80",
                     CAP_charge_flag[1], charger_en[1], cap_set_2);
        end
        settle();
    endtask

    task automatic test_abort();
        start_charge = 2'b01; set_in_1 = 8'd40;
        tick();
        start_charge = 2'b00;
        to_cycle(10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if ({charger_en[0], CAP_charge_flag[0], cap_fault[0], fault_code[1:0], cap_set_1} !==
            {3'b001, 2'd3, 8'd40}) begin
            n_fail++;
            $display("FAIL abort_inflight: got cen=%b cflag=%b flt=%b code=%0d set=%0d required 0 0 1 3 40",
                     charger_en[0], CAP_charge_flag[0], cap_fault[0], fault_code[1:0], cap_set_1);
        end
        abort = 1'b1; fault_clr = 2'b01;
        tick();
        abort = 1'b0; fault_clr = 2'b00;
        n_checks++;
        if ({cap_fault[0], fault_code[1:0]} !== 3'b111) begin
            n_fail++;
            $display("FAIL abort_beats_clr: got flt=%b code=%0d required 1 3", cap_fault[0], fault_code[1:0]);
        end
        fault_clr = 2'b01;
        tick();
        fault_clr = 2'b00;
        n_checks++;
        if ({cap_fault[0], fault_code[1:0]} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_clr: got flt=%b code=%0d required 0 0", cap_fault[0], fault_code[1:0]);
        end
        cyc = 0;
        start_charge = 2'b01; set_in_1 = 8'd60;
        tick();
        start_charge = 2'b00;
        to_cycle(6);
        voltage_reached[0] = 1'b1;
        to_cycle(9);
        n_checks++;
        if (cap_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre_ready: got rdy=%b required 1", cap_ready[0]);
        end
        to_cycle(12);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if ({cap_ready[0], cap_fault, fault_code, CAP_charge_flag[0]} !== 8'd0) begin
            n_fail++;
            $display("FAIL abort_ready: got rdy=%b flt=%b code=%h cflag=%b required 0 00 0 0",
                     cap_ready[0], cap_fault, fault_code, CAP_charge_flag[0]);
        end
        voltage_reached[0] = 1'b0;
        settle();
    endtask

    task automatic test_topup();
        start_charge = 2'b01; set_in_1 = 8'd30;
        tick();
        start_charge = 2'b00;
        to_cycle(6);
        voltage_reached[0] = 1'b1;
        to_cycle(9);
        n_checks++;
        if (cap_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL topup_ready: got rdy=%b required 1", cap_ready[0]);
        end
        to_cycle(12);
        voltage_reached[0] = 1'b0;
`ifdef CAP_TOPUP_EN
        to_cycle(21);
        n_checks++;
        if (cap_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL topup_early: cycle 21 got rdy=%b required 1", cap_ready[0]);
        end
        to_cycle(22);
        n_checks++;
        if ({cap_ready[0], charger_en[0], CAP_charge_flag[0]} !== 3'b011) begin
            n_fail++;
            $display("FAIL topup_recharge: got rdy=%b cen=%b cflag=%b required 0 1 1",
                     cap_ready[0], charger_en[0], CAP_charge_flag[0]);
        end
        voltage_reached[0] = 1'b1;
        to_cycle(28);
        n_checks++;
        if ({cap_ready[0], cap_set_1} !== {1'b1, 8'd30}) begin
            n_fail++;
            $display("FAIL topup_reready: got rdy=%b set=%0d required 1 30", cap_ready[0], cap_set_1);
        end
`else
        to_cycle(22);
        n_checks++;
        if ({cap_ready[0], charger_en[0]} !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_ready_22: got rdy=%b cen=%b required 1 0", cap_ready[0], charger_en[0]);
        end
        to_cycle(40);
        n_checks++;
        if ({cap_ready[0], charger_en[0]} !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_ready_40: got rdy=%b cen=%b required 1 0", cap_ready[0], charger_en[0]);
        end
        voltage_reached[0] = 1'b1;
`endif
        fire_done = 2'b01;
        tick();
        fire_done = 2'b00;
        n_checks++;
        if ({cap_ready[0], CAP_charge_flag[0], charger_en[0]} !== 3'b000) begin
            n_fail++;
            $display("FAIL fire_done_idle: got rdy=%b cflag=%b cen=%b required 0 0 0",
                     cap_ready[0], CAP_charge_flag[0], charger_en[0]);
        end
        voltage_reached[0] = 1'b0;
        settle();
    endtask

    initial begin
        test_reset();
        test_charge();
        test_timeout();
        test_discharge();
        test_simultaneous();
        test_zero_setpoint();
        test_abort();
        test_topup();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
